// File: rtl/isp_stream_monitor.sv
// isp_stream_monitor: passive receive-side checker for vsync/href/RGB video streams.
// Measures per-frame geometry and an RGB checksum, and reports the results once per frame.
module isp_stream_monitor #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_HDISP  = 640,
  parameter int IMG_VDISP  = 480,
  parameter int CNT_W      = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  per_frame_vsync,
  input  logic                  per_frame_hsync,
  input  logic                  per_frame_href,
  input  logic [DATA_WIDTH-1:0] per_img_red,
  input  logic [DATA_WIDTH-1:0] per_img_green,
  input  logic [DATA_WIDTH-1:0] per_img_blue,
  output logic                  frame_done,
  output logic                  frame_ok,
  output logic [CNT_W-1:0]      meas_hdisp,
  output logic [CNT_W-1:0]      meas_vdisp,
  output logic [15:0]           checksum,
  output logic                  err_hdisp,
  output logic                  err_vdisp,
  output logic                  err_sync,
  output logic [15:0]           frame_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] H_EXP   = CNT_W'(IMG_HDISP);
  localparam logic [CNT_W-1:0] V_EXP   = CNT_W'(IMG_VDISP);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + CNT_ONE;
    end
  endfunction

  state_t                state_r, state_nxt_s;
  logic                  fin_s, clear_s, close_line_s, pix_en_s, sync_hit_s;
  logic                  href_d_r, fin_d_r;
  logic [CNT_W-1:0]      pix_cnt_r, line_cnt_r, last_w_r;
  logic [15:0]           acc_r;
  logic                  err_h_pend_r, err_sync_pend_r;
  logic [DATA_WIDTH+1:0] pix_sum_s;
  logic                  err_v_s, sync_rep_s;
  logic                  unused_hsync_s;

  assign unused_hsync_s = per_frame_hsync;
  assign pix_sum_s = {2'b00, per_img_red} + {2'b00, per_img_green} + {2'b00, per_img_blue};
  // A line still open when vsync drops is closed exactly as if href had fallen.
  assign close_line_s = (state_r == ST_ACTIVE) && href_d_r && (!per_frame_href || !per_frame_vsync);
  assign pix_en_s     = (state_r == ST_ACTIVE) && per_frame_vsync && per_frame_href;
  assign sync_hit_s   = (state_r != ST_IDLE) && per_frame_href && !per_frame_vsync;
  assign err_v_s      = (line_cnt_r != V_EXP);
  assign sync_rep_s   = err_sync_pend_r | sync_hit_s;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; IDLE waits for a full vsync so a partial first frame is never reported.
  always_comb begin
    state_nxt_s = state_r;
    fin_s       = 1'b0;
    clear_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!per_frame_vsync) begin
          state_nxt_s = ST_SYNC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SYNC: begin
        if (per_frame_vsync) begin
          state_nxt_s = ST_ACTIVE;
          clear_s     = 1'b1;
        end else begin
          state_nxt_s = ST_SYNC;
        end
      end
      ST_ACTIVE: begin
        if (!per_frame_vsync) begin
          state_nxt_s = ST_SYNC;
          fin_s       = 1'b1;
        end else begin
          state_nxt_s = ST_ACTIVE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Per-frame measurement counters and accumulators.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      href_d_r        <= 1'b0;
      fin_d_r         <= 1'b0;
      pix_cnt_r       <= {CNT_W{1'b0}};
      line_cnt_r      <= {CNT_W{1'b0}};
      last_w_r        <= {CNT_W{1'b0}};
      acc_r           <= 16'd0;
      err_h_pend_r    <= 1'b0;
      err_sync_pend_r <= 1'b0;
    end else begin
      href_d_r <= per_frame_href;
      fin_d_r  <= fin_s;
      if (clear_s) begin
        pix_cnt_r    <= {CNT_W{1'b0}};
        line_cnt_r   <= {CNT_W{1'b0}};
        last_w_r     <= {CNT_W{1'b0}};
        acc_r        <= 16'd0;
        err_h_pend_r <= 1'b0;
      end else if (close_line_s) begin
        last_w_r     <= pix_cnt_r;
        line_cnt_r   <= sat_inc(line_cnt_r);
        err_h_pend_r <= err_h_pend_r | (pix_cnt_r != H_EXP);
        pix_cnt_r    <= {CNT_W{1'b0}};
      end else if (pix_en_s) begin
        pix_cnt_r <= sat_inc(pix_cnt_r);
        acc_r     <= acc_r + 16'(pix_sum_s);
      end
      // The sync error survives the frame restart and is consumed only when reported.
      if (fin_d_r) begin
        err_sync_pend_r <= 1'b0;
      end else if (sync_hit_s) begin
        err_sync_pend_r <= 1'b1;
      end
    end
  end

  // Status outputs, loaded one cycle after the frame-ending vsync edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      meas_hdisp <= {CNT_W{1'b0}};
      meas_vdisp <= {CNT_W{1'b0}};
      checksum   <= 16'd0;
      err_hdisp  <= 1'b0;
      err_vdisp  <= 1'b0;
      err_sync   <= 1'b0;
      frame_cnt  <= 16'd0;
    end else if (fin_d_r) begin
      frame_done <= 1'b1;
      frame_ok   <= ~(err_h_pend_r | err_v_s | sync_rep_s);
      meas_hdisp <= last_w_r;
      meas_vdisp <= line_cnt_r;
      checksum   <= acc_r;
      err_hdisp  <= err_h_pend_r;
      err_vdisp  <= err_v_s;
      err_sync   <= sync_rep_s;
      frame_cnt  <= frame_cnt + 16'd1;
    end else begin
      frame_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_isp_stream_monitor.sv
// Self-checking bench for isp_stream_monitor: frame tasks push expected reports to a
// scoreboard queue, and a monitor pops and compares them on every frame_done pulse.
module tb_isp_stream_monitor;
  localparam int H  = 16;
  localparam int V  = 8;
  localparam int DW = 8;
  localparam int CW = 14;

  typedef struct packed {
    logic [CW-1:0] hd;
    logic [CW-1:0] vd;
    logic [15:0]   cs;
    logic          eh;
    logic          ev;
    logic          es;
    logic          ok;
    logic [15:0]   cnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          per_frame_vsync, per_frame_hsync, per_frame_href;
  logic [DW-1:0] per_img_red, per_img_green, per_img_blue;
  logic          frame_done, frame_ok, err_hdisp, err_vdisp, err_sync;
  logic [CW-1:0] meas_hdisp, meas_vdisp;
  logic [15:0]   checksum, frame_cnt;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_cnt = 0;
  int   m_sum, m_lines, m_last_w;
  bit   m_eh;
  logic fd_prev = 1'b0;

  isp_stream_monitor #(.DATA_WIDTH(DW), .IMG_HDISP(H), .IMG_VDISP(V), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .per_frame_vsync(per_frame_vsync), .per_frame_hsync(per_frame_hsync), .per_frame_href(per_frame_href),
    .per_img_red(per_img_red), .per_img_green(per_img_green), .per_img_blue(per_img_blue),
    .frame_done(frame_done), .frame_ok(frame_ok), .meas_hdisp(meas_hdisp), .meas_vdisp(meas_vdisp),
    .checksum(checksum), .err_hdisp(err_hdisp), .err_vdisp(err_vdisp), .err_sync(err_sync),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: compare each report against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    exp_t got;
    if (rst) begin
      fd_prev = 1'b0;
    end else begin
      if (frame_done) begin
        got = {meas_hdisp, meas_vdisp, checksum, err_hdisp, err_vdisp, err_sync, frame_ok, frame_cnt};
        n_tests++;
        if (fd_prev) begin
          n_fail++;
          $display("FAIL frame_done_width: high on consecutive cycles, required one-cycle pulse");
        end else if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_frame_done: got report %h, required no pulse", got);
        end else begin
          e = sb_q.pop_front();
          if (got !== e) begin
            n_fail++;
            $display("FAIL frame_report: got hd=%0d vd=%0d cs=%h eh=%b ev=%b es=%b ok=%b cnt=%0d, required hd=%0d vd=%0d cs=%h eh=%b ev=%b es=%b ok=%b cnt=%0d",
                     got.hd, got.vd, got.cs, got.eh, got.ev, got.es, got.ok, got.cnt,
                     e.hd, e.vd, e.cs, e.eh, e.ev, e.es, e.ok, e.cnt);
          end
        end
      end
      fd_prev = frame_done;
    end
  end

  task automatic set_pixel(input int kind);
    case (kind)
      1: begin per_img_red = 8'd1; per_img_green = 8'd1; per_img_blue = 8'd1; end
      2: begin per_img_red = 8'hFF; per_img_green = 8'hFF; per_img_blue = 8'hFF; end
      default: begin
        per_img_red   = 8'($urandom_range(0, 255));
        per_img_green = 8'($urandom_range(0, 255));
        per_img_blue  = 8'($urandom_range(0, 255));
      end
    endcase
  endtask

  task automatic send_line(input int w, input int kind);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      per_frame_href = 1'b0; per_frame_hsync = 1'b0;
    end
    for (int i = 0; i < w; i++) begin
      @(negedge clk);
      per_frame_href = 1'b1; per_frame_hsync = 1'b1;
      set_pixel(kind);
      m_sum += int'(per_img_red) + int'(per_img_green) + int'(per_img_blue);
    end
    m_lines++;
    m_last_w = w;
    if (w != H) m_eh = 1'b1;
  endtask

  task automatic vsync_pulse();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      per_frame_vsync = 1'b0; per_frame_href = 1'b0;
    end
    @(negedge clk);
    per_frame_vsync = 1'b1;
    @(negedge clk);
  endtask

  // Frame of nlines lines (last one lastw wide); tail = href-high cycles into the closing vsync.
  task automatic send_frame(input int nlines, input int w, input int lastw, input int kind, input int tail);
    exp_t e;
    m_sum = 0; m_lines = 0; m_last_w = 0; m_eh = 1'b0;
    for (int l = 0; l < nlines; l++) send_line((l == nlines - 1) ? lastw : w, kind);
    exp_cnt = (exp_cnt + 1) & 16'hFFFF;
    e.hd  = CW'(m_last_w);
    e.vd  = CW'(m_lines);
    e.cs  = 16'(m_sum);
    e.eh  = m_eh;
    e.ev  = (m_lines != V);
    e.es  = (tail > 0);
    e.ok  = !(e.eh || e.ev || e.es);
    e.cnt = 16'(exp_cnt);
    sb_q.push_back(e);
    if (tail == 0) begin
      repeat (2) begin @(negedge clk); per_frame_href = 1'b0; end
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      per_frame_vsync = 1'b0;
      per_frame_href  = (i < tail);
      set_pixel(0);
    end
    @(negedge clk);
    per_frame_vsync = 1'b1; per_frame_href = 1'b0;
    @(negedge clk);
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL frame_done_timeout: %0d reports outstanding, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    per_frame_vsync = 1'b1; per_frame_hsync = 1'b0; per_frame_href = 1'b0;
    per_img_red = 8'd0; per_img_green = 8'd0; per_img_blue = 8'd0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({frame_done, frame_ok, meas_hdisp, meas_vdisp, checksum, err_hdisp, err_vdisp, err_sync, frame_cnt} !== 66'd0) begin
      n_fail++;
      $display("FAIL reset_state: got cnt=%0d hd=%0d vd=%0d cs=%h, required all zero", frame_cnt, meas_hdisp, meas_vdisp, checksum);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    vsync_pulse();
  endtask

  task automatic test_nominal();
    for (int f = 0; f < 3; f++) send_frame(V, H, H, 0, 0);
    n_tests++;
    if (frame_cnt !== 16'd3 || frame_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL nominal_count: got frame_cnt=%0d ok=%b, required 3 and 1", frame_cnt, frame_ok);
    end
  endtask

  task automatic test_checksum();
    send_frame(2, 4, 4, 1, 0);
    n_tests++;
    if (checksum !== 16'd24) begin
      n_fail++;
      $display("FAIL checksum_ones: got %h, required 0018", checksum);
    end
    send_frame(64, 64, 64, 2, 0);
    n_tests++;
    if (checksum !== 16'hD000) begin
      n_fail++;
      $display("FAIL checksum_ff: got %h, required d000", checksum);
    end
  endtask

  task automatic test_short_line();
    send_frame(V, H, H - 1, 0, 0);
  endtask

  task automatic test_short_frame();
    send_frame(V - 1, H, H, 0, 0);
    send_frame(V, H, H, 0, 0);
    n_tests++;
    if (frame_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL recover_ok: got frame_ok=%b, required 1", frame_ok);
    end
  endtask

  task automatic test_zero_lines();
    send_frame(0, H, H, 0, 0);
  endtask

  task automatic test_sync_err();
    send_frame(V, H, H, 0, 2);
    send_frame(V, H, H, 0, 0);
  endtask

  task automatic test_back_to_back();
    send_frame(V, H, H, 0, 0);
    send_frame(V, H, H + 1, 0, 0);
    send_frame(V + 1, H, H, 0, 0);
  endtask

  task automatic test_reset_mid_frame();
    send_line(H, 0);
    send_line(H, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_tests++;
    if ({frame_done, frame_ok, meas_hdisp, meas_vdisp, checksum, err_hdisp, err_vdisp, err_sync, frame_cnt} !== 66'd0) begin
      n_fail++;
      $display("FAIL reset_mid_frame: got cnt=%0d hd=%0d vd=%0d cs=%h, required all zero", frame_cnt, meas_hdisp, meas_vdisp, checksum);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    send_line(H, 0);
    send_line(H, 0);
    vsync_pulse();
    repeat (4) @(negedge clk);
    send_frame(V, H, H, 0, 0);
    n_tests++;
    if (frame_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL post_reset_count: got frame_cnt=%0d, required 1", frame_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_checksum();
    test_short_line();
    test_short_frame();
    test_zero_lines();
    test_sync_err();
    test_back_to_back();
    test_reset_mid_frame();
    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
